oitf: RTL

OITF -- requirements
Module: oitf

---
 rtl/oitf_pkg.sv | 18 +
 rtl/oitf_match.sv | 37 +++
 rtl/oitf.sv | 136 +++++++++++++
 3 files changed

// File: rtl/oitf_pkg.sv
// Shared configuration for the outstanding instruction tracking FIFO (OITF).
// Holds the default depth, the register index width and the layout of one
// tracking entry. The other OITF files import this package.
package oitf_pkg;

    localparam int OITF_DEPTH   = 4;
    localparam int OITF_RFIDX_W = 5;

    // One tracking entry, most significant field first: {vld, rdwen, rdidx}.
    typedef struct packed {
        logic                    vld;
        logic                    rdwen;
        logic [OITF_RFIDX_W-1:0] rdidx;
    } oitf_entry_t;

    localparam int OITF_ENT_W = $bits(oitf_entry_t);

endpackage

// File: rtl/oitf_match.sv
// Hazard comparator for a single OITF entry.
// Flags RAW against either enabled source operand and WAW against the
// candidate destination. An entry writing x0 never causes a hazard.
// Ports:
//   ent_vld, ent_rdwen, ent_rdidx : contents of the tracked entry
//   rs1en/rs1idx, rs2en/rs2idx    : candidate source operands
//   rdwen/rdidx                   : candidate destination
//   hit                           : entry conflicts with the candidate
module oitf_match
    import oitf_pkg::*;
#(
    parameter int RFIDX_W = OITF_RFIDX_W
) (
    input  logic               ent_vld,
    input  logic               ent_rdwen,
    input  logic [RFIDX_W-1:0] ent_rdidx,
    input  logic               rs1en,
    input  logic [RFIDX_W-1:0] rs1idx,
    input  logic               rs2en,
    input  logic [RFIDX_W-1:0] rs2idx,
    input  logic               rdwen,
    input  logic [RFIDX_W-1:0] rdidx,
    output logic               hit
);

    logic ent_live;
    logic raw1;
    logic raw2;
    logic waw;

    assign ent_live = ent_vld & ent_rdwen & (ent_rdidx != '0);
    assign raw1     = rs1en & (rs1idx == ent_rdidx);
    assign raw2     = rs2en & (rs2idx == ent_rdidx);
    assign waw      = rdwen & (rdidx  == ent_rdidx);
    assign hit      = ent_live & (raw1 | raw2 | waw);

endmodule

// File: rtl/oitf.sv
// Outstanding instruction tracking FIFO.
// Records the destination of every dispatched long-cycle instruction until
// it writes back, and blocks dispatch of any candidate that would read or
// overwrite one of those destinations.
// Ports:
//   i_clk, i_rst                    : clock, async active-high reset
//   i_inst_vld, i_flush, i_long     : dispatch candidate and its kind
//   i_exu_rdy                       : target unit can accept
//   i_rs1en/idx, i_rs2en/idx        : candidate sources
//   i_rdwen, i_rdidx                : candidate destination
//   i_ret_vld                       : oldest long instruction written back
//   o_dis_vld, o_stall              : dispatch / hold upstream
//   o_dis_tag                       : entry allocated on this dispatch
//   o_ret_rdidx                     : destination of the head entry
//   o_empty, o_full, o_cnt          : occupancy
module oitf
    import oitf_pkg::*;
#(
    parameter int DEPTH   = OITF_DEPTH,
    parameter int RFIDX_W = OITF_RFIDX_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_inst_vld,
    input  logic                     i_flush,
    input  logic                     i_long,
    input  logic                     i_exu_rdy,
    input  logic                     i_rs1en,
    input  logic                     i_rs2en,
    input  logic [RFIDX_W-1:0]       i_rs1idx,
    input  logic [RFIDX_W-1:0]       i_rs2idx,
    input  logic                     i_rdwen,
    input  logic [RFIDX_W-1:0]       i_rdidx,
    input  logic                     i_ret_vld,
    output logic                     o_dis_vld,
    output logic                     o_stall,
    output logic [$clog2(DEPTH)-1:0] o_dis_tag,
    output logic [RFIDX_W-1:0]       o_ret_rdidx,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    logic [PTR_W-1:0]              wptr_q, wptr_d;
    logic [PTR_W-1:0]              rptr_q, rptr_d;
    logic [DEPTH-1:0]              vld_q, vld_d;
    logic [DEPTH-1:0]              rdwen_q, rdwen_d;
    logic [DEPTH-1:0][RFIDX_W-1:0] rdidx_q, rdidx_d;

    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;
    logic [DEPTH-1:0] hit;
    logic             hazard;
    logic             alloc;
    logic             retire;

    assign widx = wptr_q[IDX_W-1:0];
    assign ridx = rptr_q[IDX_W-1:0];

    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (widx == ridx) & (wptr_q[IDX_W] != rptr_q[IDX_W]);
    assign o_cnt   = wptr_q - rptr_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        oitf_match #(
            .RFIDX_W (RFIDX_W)
        ) u_match (
            .ent_vld   (vld_q[g]),
            .ent_rdwen (rdwen_q[g]),
            .ent_rdidx (rdidx_q[g]),
            .rs1en     (i_rs1en),
            .rs1idx    (i_rs1idx),
            .rs2en     (i_rs2en),
            .rs2idx    (i_rs2idx),
            .rdwen     (i_rdwen),
            .rdidx     (i_rdidx),
            .hit       (hit[g])
        );
    end

    // A retiring entry still hazards this cycle; there is no bypass path.
    assign hazard = |hit;

    // Full is taken from registered pointers, so a same-cycle retirement
    // cannot open a slot for the candidate until the next cycle.
    assign o_dis_vld = i_inst_vld & ~i_flush & ~hazard & i_exu_rdy & ~(i_long & o_full);
    assign o_stall   = i_inst_vld & ~i_flush & ~o_dis_vld;

    assign o_dis_tag   = widx;
    assign o_ret_rdidx = rdidx_q[ridx];

    assign alloc  = o_dis_vld & i_long;
    assign retire = i_ret_vld & ~o_empty;

    // Allocation and retirement never target the same slot: allocation
    // needs not-full and retirement needs not-empty, and the slots only
    // coincide when the FIFO is one or the other.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        vld_d   = vld_q;
        rdwen_d = rdwen_q;
        rdidx_d = rdidx_q;
        if (retire) begin
            vld_d[ridx] = 1'b0;
            rptr_d      = rptr_q + PTR_W'(1);
        end
        if (alloc) begin
            vld_d[widx]   = 1'b1;
            rdwen_d[widx] = i_rdwen;
            rdidx_d[widx] = i_rdidx;
            wptr_d        = wptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            vld_q   <= '0;
            rdwen_q <= '0;
            rdidx_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            vld_q   <= vld_d;
            rdwen_q <= rdwen_d;
            rdidx_q <= rdidx_d;
        end
    end

endmodule
